axis_pkt_gen: RTL and testbench

- Stream packet transmitter: on a start pulse, emits a programmed number of packets of programmed length on a valid/ready/last byte stream.
- Drives the write side of the team's packet FIFO; its output ports connect directly to the FIFO's input_tdata/input_tvalid/input_tready/input_tlast.
- Serves as the bring-up traffic source for FIFO fill, backpressure and drain testing.

---
 rtl/axis_pkt_gen.sv | 189 ++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// Stream packet transmitter: on a start pulse emits pkt_count packets of pkt_len beats with gap_cycles idle cycles between them.
// Define AXIS_PKT_GEN_LFSR_EN to source output_tdata from an 8-bit Fibonacci LFSR instead of an incrementing counter.
module axis_pkt_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [CNT_W-1:0]  pkt_count,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic [DATA_W-1:0] output_tdata,
    output logic              output_tvalid,
    input  logic              output_tready,
    output logic              output_tlast,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkts_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]  ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  ONE_GAP  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONE_DATA = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_beat, w_beat_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [CNT_W-1:0]   r_sent, w_sent_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic               r_tvalid, w_tvalid_nxt;
    logic               r_tlast, w_tlast_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_xfer;

    // Data generator step; both variants start from 1 so the first beat of a run is always 0x01.
    function automatic logic [DATA_W-1:0] data_next(input logic [DATA_W-1:0] d);
`ifdef AXIS_PKT_GEN_LFSR_EN
        data_next = {d[DATA_W-2:0], d[DATA_W-1] ^ d[DATA_W-3] ^ d[DATA_W-4] ^ d[DATA_W-5]};
`else
        data_next = d + ONE_DATA;
`endif
    endfunction

    assign w_xfer        = r_tvalid & output_tready;
    assign output_tdata  = r_data;
    assign output_tvalid = r_tvalid;
    assign output_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkts_sent     = r_sent;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_beat_nxt    = r_beat;
        w_count_nxt   = r_count;
        w_sent_nxt    = r_sent;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_data_nxt    = r_data;
        w_tvalid_nxt  = r_tvalid;
        w_tlast_nxt   = r_tlast;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_len_nxt   = (pkt_len == {LEN_W{1'b0}}) ? ONE_LEN : pkt_len;
                    w_count_nxt = pkt_count;
                    w_gap_nxt   = gap_cycles;
                    w_sent_nxt  = {CNT_W{1'b0}};
                    w_data_nxt  = ONE_DATA;
                    w_beat_nxt  = ONE_LEN;
                    if (pkt_count == {CNT_W{1'b0}}) begin
                        w_state_nxt  = FIN;
                        w_done_nxt   = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                    end else begin
                        w_state_nxt  = SEND;
                        w_busy_nxt   = 1'b1;
                        w_tvalid_nxt = 1'b1;
                        w_tlast_nxt  = (w_len_nxt == ONE_LEN);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    w_data_nxt = data_next(r_data);
                    if (r_tlast) begin
                        w_sent_nxt = r_sent + ONE_CNT;
                        if (w_sent_nxt == r_count) begin
                            w_state_nxt  = FIN;
                            w_done_nxt   = 1'b1;
                            w_busy_nxt   = 1'b0;
                            w_tvalid_nxt = 1'b0;
                            w_tlast_nxt  = 1'b0;
                        end else if (r_gap != {GAP_W{1'b0}}) begin
                            w_state_nxt   = GAP;
                            w_gap_cnt_nxt = r_gap;
                            w_tvalid_nxt  = 1'b0;
                            w_tlast_nxt   = 1'b0;
                        end else begin
                            w_state_nxt  = SEND;
                            w_beat_nxt   = ONE_LEN;
                            w_tvalid_nxt = 1'b1;
                            w_tlast_nxt  = (r_len == ONE_LEN);
                        end
                    end else begin
                        w_beat_nxt  = r_beat + ONE_LEN;
                        w_tlast_nxt = (w_beat_nxt == r_len);
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            GAP: begin
                if (r_gap_cnt <= ONE_GAP) begin
                    w_state_nxt  = SEND;
                    w_beat_nxt   = ONE_LEN;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (r_len == ONE_LEN);
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - ONE_GAP;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything so tvalid drops without a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_len     <= {LEN_W{1'b0}};
            r_beat    <= {LEN_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_sent    <= {CNT_W{1'b0}};
            r_gap     <= {GAP_W{1'b0}};
            r_gap_cnt <= {GAP_W{1'b0}};
            r_data    <= {DATA_W{1'b0}};
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_beat    <= w_beat_nxt;
            r_count   <= w_count_nxt;
            r_sent    <= w_sent_nxt;
            r_gap     <= w_gap_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_data    <= w_data_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_tlast   <= w_tlast_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen: outputs sampled on the falling edge, inputs driven there too.
module tb_axis_pkt_gen;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] pkt_len;
    logic [7:0]  pkt_count;
    logic [3:0]  gap_cycles;
    logic [7:0]  output_tdata;
    logic        output_tvalid;
    logic        output_tready;
    logic        output_tlast;
    logic        busy;
    logic        done;
    logic [7:0]  pkts_sent;

    int n_checks;
    int n_fail;

    axis_pkt_gen dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .pkt_len       (pkt_len),
        .pkt_count     (pkt_count),
        .gap_cycles    (gap_cycles),
        .output_tdata  (output_tdata),
        .output_tvalid (output_tvalid),
        .output_tready (output_tready),
        .output_tlast  (output_tlast),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected data sequence for the selected generator.
    function automatic logic [7:0] nxt(input logic [7:0] d);
`ifdef AXIS_PKT_GEN_LFSR_EN
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
        return d + 8'd1;
`endif
    endfunction

    // Pulse start for one clock; called and returns on a falling edge.
    task automatic start_run(input logic [11:0] len, input logic [7:0] cnt, input logic [3:0] gap);
        pkt_len    = len;
        pkt_count  = cnt;
        gap_cycles = gap;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (output_tvalid !== 1'b0 || output_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pkts_sent !== 8'd0 || output_tdata !== 8'd0) begin
            $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b sent=%0d data=%0d, want all 0",
                     output_tvalid, output_tlast, busy, done, pkts_sent, output_tdata);
            n_fail++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (output_tvalid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_idle: valid=%b busy=%b, want 0 0", output_tvalid, busy);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d;
        logic       exp_l;
        output_tready = 1'b1;
        start_run(12'd16, 8'd4, 4'd0);
        exp_d = 8'd1;
        for (int b = 0; b < 64; b++) begin
            exp_l = ((b % 16) == 15);
            n_checks++;
            if (output_tvalid !== 1'b1 || busy !== 1'b1 || output_tdata !== exp_d || output_tlast !== exp_l) begin
                $display("FAIL basic_beat%0d: valid=%b busy=%b data=%0d last=%b, want 1 1 %0d %b",
                         b + 1, output_tvalid, busy, output_tdata, output_tlast, exp_d, exp_l);
                n_fail++;
            end
            exp_d = nxt(exp_d);
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || output_tvalid !== 1'b0 || pkts_sent !== 8'd4) begin
            $display("FAIL basic_done: done=%b busy=%b valid=%b sent=%0d, want 1 0 0 4",
                     done, busy, output_tvalid, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || output_tvalid !== 1'b0 || pkts_sent !== 8'd4) begin
            $display("FAIL basic_after: done=%b busy=%b valid=%b sent=%0d, want 0 0 0 4",
                     done, busy, output_tvalid, pkts_sent);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d;
        logic       exp_l;
        logic       rdy;
        int         beats;
        start_run(12'd16, 8'd4, 4'd0);
        exp_d = 8'd1;
        beats = 0;
        for (int c = 0; c < 2000 && beats < 64; c++) begin
            exp_l = ((beats % 16) == 15);
            n_checks++;
            if (output_tvalid !== 1'b1 || output_tdata !== exp_d || output_tlast !== exp_l) begin
                $display("FAIL bp_beat%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                         beats + 1, output_tvalid, output_tdata, output_tlast, exp_d, exp_l);
                n_fail++;
            end
            rdy = 1'($urandom_range(0, 1));
            output_tready = rdy;
            if (rdy) begin
                beats++;
                exp_d = nxt(exp_d);
            end
            @(negedge clk);
        end
        output_tready = 1'b1;
        n_checks++;
        if (beats != 64) begin
            $display("FAIL bp_count: transfers=%0d, want 64", beats);
            n_fail++;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || output_tvalid !== 1'b0 || pkts_sent !== 8'd4) begin
            $display("FAIL bp_done: done=%b busy=%b valid=%b sent=%0d, want 1 0 0 4",
                     done, busy, output_tvalid, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_gap();
        logic [7:0] exp_d;
        logic       exp_l;
        int         beats;
        int         idle;
        int         exp_idle;
        output_tready = 1'b1;
        start_run(12'd4, 8'd3, 4'd3);
        exp_d = 8'd1;
        beats = 0;
        idle  = 0;
        for (int c = 0; c < 100 && beats < 12; c++) begin
            if (output_tvalid === 1'b1) begin
                exp_l    = ((beats % 4) == 3);
                exp_idle = (beats > 0 && (beats % 4) == 0) ? 3 : 0;
                n_checks++;
                if (output_tdata !== exp_d || output_tlast !== exp_l || idle != exp_idle) begin
                    $display("FAIL gap_beat%0d: data=%0d last=%b idle_before=%0d, want %0d %b %0d",
                             beats + 1, output_tdata, output_tlast, idle, exp_d, exp_l, exp_idle);
                    n_fail++;
                end
                beats++;
                exp_d = nxt(exp_d);
                idle  = 0;
            end else begin
                idle++;
                n_checks++;
                if (busy !== 1'b1) begin
                    $display("FAIL gap_busy: busy=%b during gap, want 1", busy);
                    n_fail++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (beats != 12) begin
            $display("FAIL gap_count: beats=%0d, want 12", beats);
            n_fail++;
        end
        n_checks++;
        if (done !== 1'b1 || output_tvalid !== 1'b0 || pkts_sent !== 8'd3) begin
            $display("FAIL gap_done: done=%b valid=%b sent=%0d, want 1 0 3", done, output_tvalid, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d;
        logic       exp_l;
        output_tready = 1'b1;
        start_run(12'd300, 8'd1, 4'd0);
        exp_d = 8'd1;
        for (int b = 0; b < 300; b++) begin
            exp_l = (b == 299);
            n_checks++;
            if (output_tvalid !== 1'b1 || output_tdata !== exp_d || output_tlast !== exp_l) begin
                $display("FAIL wrap_beat%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                         b + 1, output_tvalid, output_tdata, output_tlast, exp_d, exp_l);
                n_fail++;
            end
`ifndef AXIS_PKT_GEN_LFSR_EN
            if (b == 255 || b == 299) begin
                n_checks++;
                if (output_tdata !== ((b == 255) ? 8'h00 : 8'h2C)) begin
                    $display("FAIL wrap_point%0d: data=%0d, want %0d", b + 1, output_tdata,
                             (b == 255) ? 0 : 44);
                    n_fail++;
                end
            end
`endif
            exp_d = nxt(exp_d);
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || pkts_sent !== 8'd1) begin
            $display("FAIL wrap_done: done=%b sent=%0d, want 1 1", done, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d;
        output_tready = 1'b1;
        start_run(12'd16, 8'd2, 4'd0);
        exp_d = 8'd1;
        for (int b = 0; b < 22; b++) begin
            exp_d = nxt(exp_d);
            @(negedge clk);
        end
        output_tready = 1'b0;
        n_checks++;
        if (output_tvalid !== 1'b1 || output_tdata !== exp_d || pkts_sent !== 8'd1 || busy !== 1'b1) begin
            $display("FAIL rst_pre: valid=%b data=%0d sent=%0d busy=%b, want 1 %0d 1 1",
                     output_tvalid, output_tdata, pkts_sent, busy, exp_d);
            n_fail++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (output_tvalid !== 1'b0 || output_tlast !== 1'b0 || busy !== 1'b0 || pkts_sent !== 8'd0) begin
            $display("FAIL rst_async: valid=%b last=%b busy=%b sent=%0d, want 0 0 0 0",
                     output_tvalid, output_tlast, busy, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (output_tvalid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_abandon: valid=%b busy=%b, want 0 0", output_tvalid, busy);
            n_fail++;
        end
        output_tready = 1'b1;
        start_run(12'd16, 8'd1, 4'd0);
        exp_d = 8'd1;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (output_tvalid !== 1'b1 || output_tdata !== exp_d) begin
                $display("FAIL rst_restart_beat%0d: valid=%b data=%0d, want 1 %0d",
                         b + 1, output_tvalid, output_tdata, exp_d);
                n_fail++;
            end
            exp_d = nxt(exp_d);
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || pkts_sent !== 8'd1) begin
            $display("FAIL rst_restart_done: done=%b sent=%0d, want 1 1", done, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        logic [7:0] exp_d;
        logic       exp_l;
        output_tready = 1'b0;
        start_run(12'd4, 8'd2, 4'd0);
        @(negedge clk);
        start_run(12'd8, 8'd5, 4'd2);
        output_tready = 1'b1;
        exp_d = 8'd1;
        for (int b = 0; b < 8; b++) begin
            exp_l = ((b % 4) == 3);
            n_checks++;
            if (output_tvalid !== 1'b1 || output_tdata !== exp_d || output_tlast !== exp_l) begin
                $display("FAIL busy_start_beat%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                         b + 1, output_tvalid, output_tdata, output_tlast, exp_d, exp_l);
                n_fail++;
            end
            exp_d = nxt(exp_d);
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || pkts_sent !== 8'd2 || output_tvalid !== 1'b0) begin
            $display("FAIL busy_start_done: done=%b sent=%0d valid=%b, want 1 2 0",
                     done, pkts_sent, output_tvalid);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start_run(12'd5, 8'd0, 4'd0);
        n_checks++;
        if (done !== 1'b1 || output_tvalid !== 1'b0 || busy !== 1'b0 || pkts_sent !== 8'd0) begin
            $display("FAIL zero_done: done=%b valid=%b busy=%b sent=%0d, want 1 0 0 0",
                     done, output_tvalid, busy, pkts_sent);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || output_tvalid !== 1'b0) begin
            $display("FAIL zero_after: done=%b valid=%b, want 0 0", done, output_tvalid);
            n_fail++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        pkt_len       = 12'd0;
        pkt_count     = 8'd0;
        gap_cycles    = 4'd0;
        output_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_wrap();
        test_reset_mid();
        test_busy_start();
        test_zero_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
